// File: rtl/feature_frame_buffer.sv
// Ping-pong frame buffer: a serial stream of feature words fills one bank
// while the other full bank is presented to dense1 as a packed frame.
module feature_frame_buffer #(
  parameter int FLOAT_W     = 32,
  parameter int NB_FEATURES = 42,
  parameter int DROP_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [FLOAT_W-1:0]             in_data_i,
  input  logic                           in_last_i,
  output logic [NB_FEATURES*FLOAT_W-1:0] frame_out_o,
  output logic                           frame_valid_o,
  input  logic                           frame_ready_i,
  output logic                           err_framing_o,
  output logic [DROP_W-1:0]              drop_cnt_o
);

  localparam int IDX_W = $clog2(NB_FEATURES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_FEATURES - 1);

  // Occupancy = number of full banks.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e              state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic              err_q, err_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  // Two banks of feature words; contents are only meaningful when occupancy says so.
  logic [FLOAT_W-1:0] bank_q [0:1][0:NB_FEATURES-1];

  logic acc_fire;
  logic rel_fire;
  logic last_slot;
  logic commit;

  // Ready/valid come straight from the registered occupancy, so no
  // combinational path exists from frame_ready_i to in_ready_o.
  assign in_ready_o    = (state_q != TWO);
  assign frame_valid_o = (state_q != EMPTY);
  assign err_framing_o = err_q;
  assign drop_cnt_o    = drop_q;

  assign acc_fire  = in_valid_i && in_ready_o;
  assign rel_fire  = frame_valid_o && frame_ready_i;
  assign last_slot = (wr_idx_q == LAST_IDX);
  assign commit    = acc_fire && last_slot;

  // Frame bus shows the read bank only while it holds a committed frame.
  // The read bank is never the bank being written, so the bus is stable
  // while the consumer stalls.
  genvar gi;
  generate
    for (gi = 0; gi < NB_FEATURES; gi++) begin : g_slot
      assign frame_out_o[gi*FLOAT_W +: FLOAT_W] =
        frame_valid_o ? bank_q[rd_sel_q][gi] : '0;
    end
  endgenerate

  // Bank write port: store each accepted word at the current slot.
  always_ff @(posedge clk) begin
    if (acc_fire) begin
      bank_q[wr_sel_q][wr_idx_q] <= in_data_i;
    end
  end

  // Next-state logic for occupancy, pointers, framing checks and drop counter.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    err_d    = 1'b0;
    drop_d   = drop_q;

    if (acc_fire) begin
      if (last_slot) begin
        // Full frame: commit even if the producer forgot in_last, but flag it.
        wr_idx_d = '0;
        wr_sel_d = ~wr_sel_q;
        if (!in_last_i) begin
          err_d = 1'b1;
        end
      end else if (in_last_i) begin
        // Short frame: discard the partial bank and count the drop.
        wr_idx_d = '0;
        err_d    = 1'b1;
        if (drop_q != {DROP_W{1'b1}}) begin
          drop_d = drop_q + DROP_W'(1);
        end
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end

    if (rel_fire) begin
      rd_sel_d = ~rd_sel_q;
    end

    unique case (state_q)
      EMPTY: if (commit) state_d = ONE;
      ONE: begin
        if (commit && !rel_fire)      state_d = TWO;
        else if (rel_fire && !commit) state_d = EMPTY;
      end
      TWO:     if (rel_fire) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // State register; reset discards partial and committed frames alike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wr_idx_q <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_feature_frame_buffer.sv
// Directed testbench for feature_frame_buffer.
module tb_feature_frame_buffer;

  localparam int W  = 32;
  localparam int NB = 42;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      in_data = '0;
  logic              in_last = 1'b0;
  logic [NB*W-1:0]   frame_out;
  logic              frame_valid;
  logic              frame_ready = 1'b0;
  logic              err_framing;
  logic [DW-1:0]     drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  feature_frame_buffer #(.FLOAT_W(W), .NB_FEATURES(NB), .DROP_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .in_last_i     (in_last),
    .frame_out_o   (frame_out),
    .frame_valid_o (frame_valid),
    .frame_ready_i (frame_ready),
    .err_framing_o (err_framing),
    .drop_cnt_o    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the edge that accepts it.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int waitc;
    waitc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && waitc < 100) begin
      tick();
      waitc++;
    end
    if (!in_ready) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Send n beats base+k; in_last is raised on beat last_k (-1 = never).
  task automatic send_frame(input logic [31:0] base, input int n, input int last_k);
    for (int k = 0; k < n; k++) begin
      send_beat(base + k, (k == last_k));
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] base);
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("%s[%0d]", tag, k), frame_out[k*W +: W], base + k);
    end
  endtask

  task automatic pulse_ready();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_err", {31'd0, err_framing}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    chk("rst_out0", frame_out[31:0], 32'd0);
    rst_n = 1'b1;
    tick();
    $display("[tb] reset released");

    // Reset mid-frame at wr_idx=17
    send_frame(32'hDEAD0000, 17, -1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, frame_valid}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_drop", {24'd0, drop_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    $display("[tb] mid-frame reset applied");

    // Single frame, consumer always ready
    frame_ready = 1'b1;
    send_frame(32'h3F800000, 41, -1);
    chk("single_pre_valid", {31'd0, frame_valid}, 32'd0);
    send_beat(32'h3F800000 + 41, 1'b1);
    chk("single_valid", {31'd0, frame_valid}, 32'd1);
    chk("single_err", {31'd0, err_framing}, 32'd0);
    check_frame("single", 32'h3F800000);
    tick();
    chk("single_released", {31'd0, frame_valid}, 32'd0);
    frame_ready = 1'b0;
    $display("[tb] single frame delivered");

    // Back-pressure: two frames with consumer stalled
    send_frame(32'h40000000, NB, NB-1);
    chk("bp_ready_after1", {31'd0, in_ready}, 32'd1);
    send_frame(32'h41000000, NB, NB-1);
    chk("bp_ready_after2", {31'd0, in_ready}, 32'd0);
    chk("bp_valid", {31'd0, frame_valid}, 32'd1);
    check_frame("bp_f0", 32'h40000000);
    tick();
    tick();
    tick();
    chk("bp_hold0", frame_out[31:0], 32'h40000000);
    chk("bp_hold41", frame_out[41*W +: W], 32'h40000000 + 41);
    pulse_ready();
    chk("bp_ready_after_rel", {31'd0, in_ready}, 32'd1);
    chk("bp_valid_f1", {31'd0, frame_valid}, 32'd1);
    check_frame("bp_f1", 32'h41000000);
    pulse_ready();
    chk("bp_drained", {31'd0, frame_valid}, 32'd0);
    $display("[tb] back-pressure sequence done");

    // Early in_last on beat 9
    send_frame(32'h42100000, 10, 9);
    chk("early_err", {31'd0, err_framing}, 32'd1);
    chk("early_drop", {24'd0, drop_cnt}, 32'd1);
    chk("early_valid", {31'd0, frame_valid}, 32'd0);
    tick();
    chk("early_err_clr", {31'd0, err_framing}, 32'd0);
    send_frame(32'h42000000, NB, NB-1);
    chk("after_early_valid", {31'd0, frame_valid}, 32'd1);
    check_frame("after_early", 32'h42000000);
    pulse_ready();
    $display("[tb] early-last frame dropped");

    // Missing in_last on final beat: commit, flag, no drop
    send_frame(32'h43000000, NB, -1);
    chk("nolast_valid", {31'd0, frame_valid}, 32'd1);
    chk("nolast_err", {31'd0, err_framing}, 32'd1);
    chk("nolast_drop", {24'd0, drop_cnt}, 32'd1);
    chk("nolast_s41", frame_out[41*W +: W], 32'h43000000 + 41);
    pulse_ready();
    chk("nolast_released", {31'd0, frame_valid}, 32'd0);
    $display("[tb] missing-last frame committed");

    // Simultaneous commit and release in state ONE
    send_frame(32'h44000000, NB, NB-1);
    send_frame(32'h45000000, NB-1, -1);
    chk("sim_pre_f0", frame_out[0 +: W], 32'h44000000);
    in_valid    = 1'b1;
    in_data     = 32'h45000000 + 41;
    in_last     = 1'b1;
    frame_ready = 1'b1;
    tick();
    in_valid    = 1'b0;
    in_last     = 1'b0;
    frame_ready = 1'b0;
    chk("sim_valid", {31'd0, frame_valid}, 32'd1);
    chk("sim_ready", {31'd0, in_ready}, 32'd1);
    check_frame("sim_new", 32'h45000000);
    pulse_ready();
    chk("sim_no_dup", {31'd0, frame_valid}, 32'd0);
    $display("[tb] simultaneous commit/release done");

    // Drop counter saturation: 300 single-beat early-last frames
    for (int i = 0; i < 253; i++) send_beat(32'h50000000 + i, 1'b1);
    chk("sat_254", {24'd0, drop_cnt}, 32'd254);
    for (int i = 0; i < 47; i++) send_beat(32'h51000000 + i, 1'b1);
    chk("sat_255", {24'd0, drop_cnt}, 32'd255);
    chk("sat_err", {31'd0, err_framing}, 32'd1);
    chk("sat_valid", {31'd0, frame_valid}, 32'd0);
    tick();
    chk("sat_err_clr", {31'd0, err_framing}, 32'd0);
    $display("[tb] drop counter saturation done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
